// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, FSM states and address field extraction for the data cache
package cache_pkg;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int INDEX_W  = 4;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam int LINES    = 1 << INDEX_W;
  localparam int WORDS    = 1 << OFFSET_W;
  localparam int WADDR_W  = ADDR_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_WRITEBACK,
    ST_ALLOCATE
  } state_e;

  // Extractors operate on the word address (byte address >> 2).
  function automatic logic [TAG_W-1:0] addr_tag(input logic [WADDR_W-1:0] waddr);
    return waddr[WADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [WADDR_W-1:0] waddr);
    return waddr[OFFSET_W+INDEX_W-1:OFFSET_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [WADDR_W-1:0] waddr);
    return waddr[OFFSET_W-1:0];
  endfunction
endpackage

// File: rtl/cache_line_store.sv
// rtl/cache_line_store.sv - tag/valid/dirty/data arrays, async read by index, sync writes
module cache_line_store
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  index,
  input  logic [OFFSET_W-1:0] rd_offset,
  output logic [TAG_W-1:0]    rd_tag,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [DATA_W-1:0]   rd_word,
  input  logic                word_we,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                dirty_set,
  input  logic                dirty_clr,
  input  logic                fill_done,
  input  logic [TAG_W-1:0]    fill_tag
);
  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES][WORDS];

  assign rd_tag   = tag_q[index];
  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_word  = data_q[index][rd_offset];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (dirty_set) dirty_d[index] = 1'b1;
    if (dirty_clr) dirty_d[index] = 1'b0;
    if (fill_done) begin
      valid_d[index] = 1'b1;
      dirty_d[index] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data contents are meaningless until valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (word_we) data_q[index][wr_offset] <= wr_data;
    if (fill_done) tag_q[index] <= fill_tag;
  end
endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
module cache_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  state_e               state_q, state_d;
  logic [OFFSET_W-1:0]  cnt_q, cnt_d;
  logic                 req_we_q, req_we_d;
  logic [WADDR_W-1:0]   req_waddr_q, req_waddr_d;
  logic [DATA_W-1:0]    req_wdata_q, req_wdata_d;

  logic [INDEX_W-1:0]   idx;
  logic [TAG_W-1:0]     req_tag;
  logic [OFFSET_W-1:0]  req_off;
  logic [OFFSET_W-1:0]  rd_offset;
  logic [TAG_W-1:0]     line_tag;
  logic                 line_valid, line_dirty;
  logic [DATA_W-1:0]    line_word;
  logic                 word_we, dirty_set, dirty_clr, fill_done;
  logic [OFFSET_W-1:0]  wr_offset;
  logic [DATA_W-1:0]    wr_data;
  logic                 hit, last_word;
  logic                 addr_lsb_unused;

  assign addr_lsb_unused = ^cpu_addr[1:0];

  assign idx       = addr_index(req_waddr_q);
  assign req_tag   = addr_tag(req_waddr_q);
  assign req_off   = addr_offset(req_waddr_q);
  assign rd_offset = (state_q == ST_COMPARE) ? req_off : cnt_q;
  assign hit       = line_valid && (line_tag == req_tag);
  assign last_word = (cnt_q == {OFFSET_W{1'b1}});

  cache_line_store u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .index     (idx),
    .rd_offset (rd_offset),
    .rd_tag    (line_tag),
    .rd_valid  (line_valid),
    .rd_dirty  (line_dirty),
    .rd_word   (line_word),
    .word_we   (word_we),
    .wr_offset (wr_offset),
    .wr_data   (wr_data),
    .dirty_set (dirty_set),
    .dirty_clr (dirty_clr),
    .fill_done (fill_done),
    .fill_tag  (req_tag)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_we_d    = req_we_q;
    req_waddr_d = req_waddr_q;
    req_wdata_d = req_wdata_q;
    cpu_ready   = 1'b0;
    cpu_rdata   = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    word_we     = 1'b0;
    wr_offset   = req_off;
    wr_data     = req_wdata_q;
    dirty_set   = 1'b0;
    dirty_clr   = 1'b0;
    fill_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          req_we_d    = cpu_we;
          req_waddr_d = cpu_addr[ADDR_W-1:2];
          req_wdata_d = cpu_wdata;
          state_d     = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (hit) begin
          cpu_ready = 1'b1;
          if (req_we_q) begin
            word_we   = 1'b1;
            dirty_set = 1'b1;
          end else begin
            cpu_rdata = line_word;
          end
          state_d = ST_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = (line_valid && line_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {line_tag, idx, cnt_q, 2'b00};
        mem_wdata = line_word;
        if (mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (last_word) begin
            dirty_clr = 1'b1;
            state_d   = ST_ALLOCATE;
          end
        end
      end
      ST_ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, idx, cnt_q, 2'b00};
        if (mem_ack) begin
          word_we   = 1'b1;
          wr_offset = cnt_q;
          wr_data   = mem_rdata;
          cnt_d     = cnt_q + 1'b1;
          // Return to COMPARE so a pending store merges into the fresh line.
          if (last_word) begin
            fill_done = 1'b1;
            state_d   = ST_COMPARE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_we_q    <= 1'b0;
      req_waddr_q <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_we_q    <= req_we_d;
      req_waddr_q <= req_waddr_d;
      req_wdata_q <= req_wdata_d;
    end
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - directed self-checking bench for cache_ctrl with a latency memory model
module tb_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [31:0] log_addr [256];
  logic [31:0] log_wdata [256];
  logic        log_we [256];
  int          log_n = 0;
  int          wcnt = 0;
  int          stall_len = 0;
  int          stall_seen = 0;

  cache_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  // Memory: each word is acked on the second request cycle; stall cycles are inserted once.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (stall_seen < stall_len) begin
        stall_seen++;
      end else begin
        wcnt++;
        if (wcnt == 2) begin
          wcnt      = 0;
          mem_ack   = 1'b1;
          mem_rdata = mem_addr ^ 32'hA5A5_0000;
          if (log_n < 256) begin
            log_addr[log_n]  = mem_addr;
            log_wdata[log_n] = mem_wdata;
            log_we[log_n]    = mem_we;
            log_n++;
          end
        end
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the controller back in IDLE.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      cpu_req = 1'b0;
      lat++;
    end while (!cpu_ready && lat < 500);
    rd = cpu_rdata;
    if (!cpu_ready) check_eq("access_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    int          s;
    int          unstable;
    int          ready_seen;
    int          found;
    logic [31:0] wb_exp [4];

    wb_exp[0] = 32'hA5A5_0040;
    wb_exp[1] = 32'hDEAD_BEEF;
    wb_exp[2] = 32'hA5A5_0048;
    wb_exp[3] = 32'hA5A5_004C;

    repeat (2) @(negedge clk);
    check_eq("reset_outs", {29'd0, cpu_ready, mem_req, mem_we}, 32'd0);
    check_eq("reset_data", mem_addr | mem_wdata | cpu_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. cold load
    s = log_n;
    access(1'b0, 32'h0000_0040, '0, rd, lat);
    check_eq("t1_nwords", log_n - s, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("t1_addr", log_addr[s+i], 32'h40 + 4 * i);
      check_eq("t1_we", {31'd0, log_we[s+i]}, 32'd0);
    end
    check_eq("t1_rdata", rd, 32'hA5A5_0040);
    s = log_n;
    access(1'b0, 32'h0000_0044, '0, rd, lat);
    check_eq("t1_hit_lat", lat, 1);
    check_eq("t1_hit_nomem", log_n - s, 0);
    check_eq("t1_hit_rdata", rd, 32'hA5A5_0044);

    // 2. store hit
    s = log_n;
    access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, rd, lat);
    check_eq("t2_lat", lat, 1);
    access(1'b0, 32'h0000_0044, '0, rd, lat);
    check_eq("t2_nomem", log_n - s, 0);
    check_eq("t2_rdata", rd, 32'hDEAD_BEEF);

    // 3. dirty victim
    s = log_n;
    access(1'b0, 32'h0000_0140, '0, rd, lat);
    check_eq("t3_nwords", log_n - s, 8);
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_wb_addr", log_addr[s+i], 32'h40 + 4 * i);
      check_eq("t3_wb_we", {31'd0, log_we[s+i]}, 32'd1);
      check_eq("t3_wb_data", log_wdata[s+i], wb_exp[i]);
      check_eq("t3_rd_addr", log_addr[s+4+i], 32'h140 + 4 * i);
      check_eq("t3_rd_we", {31'd0, log_we[s+4+i]}, 32'd0);
    end
    check_eq("t3_rdata", rd, 32'hA5A5_0140);

    // 4. clean victim, then a cold store miss that merges after refill
    s = log_n;
    access(1'b0, 32'h0000_0240, '0, rd, lat);
    check_eq("t4_nwords", log_n - s, 4);
    check_eq("t4_first", log_addr[s], 32'h240);
    check_eq("t4_nowrite", {31'd0, log_we[s] | log_we[s+1] | log_we[s+2] | log_we[s+3]}, 32'd0);
    check_eq("t4_rdata", rd, 32'hA5A5_0240);
    access(1'b1, 32'h0000_0084, 32'h0BAD_F00D, rd, lat);
    access(1'b0, 32'h0000_0084, '0, rd, lat);
    check_eq("t4_merge", rd, 32'h0BAD_F00D);
    access(1'b0, 32'h0000_0088, '0, rd, lat);
    check_eq("t4_merge_nbr", rd, 32'hA5A5_0088);

    // 5. stalled writeback with request noise
    access(1'b1, 32'h0000_0240, 32'h1234_5678, rd, lat);
    s = log_n;
    stall_len = 10;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0340;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    @(posedge clk);
    unstable = 0;
    ready_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check_eq("t5_wb_addr", mem_addr, 32'h240);
        check_eq("t5_wb_data", mem_wdata, 32'h1234_5678);
        check_eq("t5_wb_we", {31'd0, mem_we}, 32'd1);
      end else if (mem_addr !== 32'h240 || mem_wdata !== 32'h1234_5678 || mem_req !== 1'b1) begin
        unstable++;
      end
      if (cpu_ready) ready_seen++;
      cpu_req   = i[0];
      cpu_we    = 1'b1;
      cpu_addr  = 32'h0000_0044;
      cpu_wdata = 32'hBAAD_BAAD;
    end
    cpu_req = 1'b0;
    check_eq("t5_stable", unstable, 0);
    check_eq("t5_no_ready", ready_seen, 0);
    lat = 0;
    while (!cpu_ready && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    check_eq("t5_done", {31'd0, cpu_ready}, 32'd1);
    check_eq("t5_rdata", cpu_rdata, 32'hA5A5_0340);
    check_eq("t5_nwords", log_n - s, 8);
    ready_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (cpu_ready) ready_seen++;
    end
    check_eq("t5_no_extra", ready_seen, 0);
    access(1'b0, 32'h0000_0044, '0, rd, lat);
    check_eq("t5_44_refetch", rd, 32'hA5A5_0044);

    // 6. reset mid-refill (line 4 now holds a clean 0x0 tag after the reload above)
    access(1'b0, 32'h0000_0340, '0, rd, lat);
    access(1'b0, 32'h0000_0140, '0, rd, lat);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0040;
    @(posedge clk);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      if (mem_req && !mem_we && mem_addr == 32'h48) found = 1;
    end
    check_eq("t6_reach_w2", found, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_outs", {29'd0, cpu_ready, mem_req, mem_we}, 32'd0);
    check_eq("t6_rst_data", mem_addr | mem_wdata | cpu_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    s = log_n;
    access(1'b0, 32'h0000_0140, '0, rd, lat);
    check_eq("t6_nwords", log_n - s, 4);
    check_eq("t6_nowrite", {31'd0, log_we[s] | log_we[s+1] | log_we[s+2] | log_we[s+3]}, 32'd0);
    check_eq("t6_first", log_addr[s], 32'h140);
    check_eq("t6_rdata", rd, 32'hA5A5_0140);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
